// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and defaults for the serial-parallel multiplier
package spm_pkg;

  localparam int SPM_CNT_W      = 4;
  localparam int SPM_DEFAULT_TC = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } spm_state_e;

endpackage

// File: rtl/eq_cmp.sv
// rtl/eq_cmp.sv - parametrised equality comparator
module eq_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/spm_step_sequencer.sv
// rtl/spm_step_sequencer.sv - programmable-length step sequencer for the signed multiplier
module spm_step_sequencer
  import spm_pkg::*;
#(
  parameter int CNT_W      = SPM_CNT_W,
  parameter int DEFAULT_TC = SPM_DEFAULT_TC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             tc_load,
  input  logic [CNT_W-1:0] tc_in,
  input  logic             auto_reload,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             done
);

  spm_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] tc_q;
  logic             busy_q;
  logic             done_q;
  logic             cnt_eq_tc;
  logic [CNT_W-1:0] count_inc_d;
  logic             last_d;

  eq_cmp #(.WIDTH(CNT_W)) u_eq_cmp (
    .a  (count_q),
    .b  (tc_q),
    .eq (cnt_eq_tc)
  );

  // count never passes tc_q, so the increment cannot wrap past the terminal value
  assign count_inc_d = count_q + CNT_W'(1);
  assign last_d      = (state_q == ST_RUN) && cnt_eq_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= CNT_W'(DEFAULT_TC);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            count_q <= '0;
            if (tc_load) tc_q <= tc_in;
            if (start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (last_d) begin
              done_q <= 1'b1;
              if (auto_reload) begin
                count_q <= '0;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end
            end else begin
              count_q <= count_inc_d;
            end
          end
          ST_DONE: begin
            if (tc_load) tc_q <= tc_in;
            count_q <= '0;
            if (start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign count = count_q;
  assign last  = last_d;
  assign done  = done_q;

endmodule

// File: tb/tb_spm_step_sequencer.sv
// tb/tb_spm_step_sequencer.sv - directed self-checking bench for spm_step_sequencer
module tb_spm_step_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       tc_load;
  logic [3:0] tc_in;
  logic       auto_reload;
  logic       busy;
  logic [3:0] count;
  logic       last;
  logic       done;

  int n_pass;
  int n_total;

  // observed vector: {busy, count, last, done}
  wire [6:0] obs = {busy, count, last, done};

  spm_step_sequencer #(.CNT_W(4), .DEFAULT_TC(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .tc_load     (tc_load),
    .tc_in       (tc_in),
    .auto_reload (auto_reload),
    .busy        (busy),
    .count       (count),
    .last        (last),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] exp;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    exp = 7'b0_0000_0_0;
    n_total++;
    if (obs !== exp) $display("FAIL reset: got %b want %b", obs, exp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_default_run;
    logic [6:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, 4'(i), (i == 15), 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL default_run step %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      tick();
    end
    exp = 7'b0_1111_0_1;
    n_total++;
    if (obs !== exp) $display("FAIL default_done: got %b want %b", obs, exp);
    else n_pass++;
    tick();
    exp = 7'b0_0000_0_0;
    n_total++;
    if (obs !== exp) $display("FAIL default_idle: got %b want %b", obs, exp);
    else n_pass++;
  endtask

  task automatic test_tc_load;
    logic [6:0] exp;
    tc_load = 1'b1;
    tc_in   = 4'd3;
    tick();
    tc_load = 1'b0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp = {1'b1, 4'(i), (i == 3), 1'b0};
        n_total++;
        if (obs !== exp) $display("FAIL tc3_run%0d step %0d: got %b want %b", r, i, obs, exp);
        else n_pass++;
        if (r == 0 && i == 1) begin
          tc_load = 1'b1;
          tc_in   = 4'd9;
        end else begin
          tc_load = 1'b0;
        end
        tick();
      end
      exp = 7'b0_0011_0_1;
      n_total++;
      if (obs !== exp) $display("FAIL tc3_done%0d: got %b want %b", r, obs, exp);
      else n_pass++;
      tick();
      exp = 7'b0_0000_0_0;
      n_total++;
      if (obs !== exp) $display("FAIL tc3_idle%0d: got %b want %b", r, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    tc_load = 1'b1;
    tc_in   = 4'd0;
    start   = 1'b1;
    tick();
    tc_load = 1'b0;
    exp = 7'b1_0000_1_0;
    n_total++;
    if (obs !== exp) $display("FAIL tc0_first: got %b want %b", obs, exp);
    else n_pass++;
    tick();
    exp = 7'b0_0000_0_1;
    n_total++;
    if (obs !== exp) $display("FAIL tc0_done1: got %b want %b", obs, exp);
    else n_pass++;
    tick();
    exp = 7'b1_0000_1_0;
    n_total++;
    if (obs !== exp) $display("FAIL b2b_rerun: got %b want %b", obs, exp);
    else n_pass++;
    start = 1'b0;
    tick();
    exp = 7'b0_0000_0_1;
    n_total++;
    if (obs !== exp) $display("FAIL tc0_done2: got %b want %b", obs, exp);
    else n_pass++;
    tick();
    exp = 7'b0_0000_0_0;
    n_total++;
    if (obs !== exp) $display("FAIL tc0_idle: got %b want %b", obs, exp);
    else n_pass++;
  endtask

  task automatic test_auto_reload;
    logic [6:0] exp_seq [8];
    exp_seq = '{7'b1_0000_0_0, 7'b1_0001_0_0, 7'b1_0010_1_0, 7'b1_0000_0_1,
                7'b1_0001_0_0, 7'b1_0010_1_0, 7'b0_0010_0_1, 7'b0_0000_0_0};
    tc_load = 1'b1;
    tc_in   = 4'd2;
    tick();
    tc_load     = 1'b0;
    auto_reload = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (obs !== exp_seq[i]) $display("FAIL reload cyc %0d: got %b want %b", i, obs, exp_seq[i]);
      else n_pass++;
      if (i == 4) auto_reload = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort;
    logic [6:0] exp;
    tc_load = 1'b1;
    tc_in   = 4'd15;
    tick();
    tc_load = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 4'(i), 1'b0, 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL abort_pre step %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i < 5) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = 7'b0_0000_0_0;
      n_total++;
      if (obs !== exp) $display("FAIL abort_mid cyc %0d: got %b want %b", k, obs, exp);
      else n_pass++;
      tick();
    end
    tc_load = 1'b1;
    tc_in   = 4'd2;
    tick();
    tc_load = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 4'(i), (i == 2), 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL abort_last_pre step %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i < 2) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = 7'b0_0000_0_0;
      n_total++;
      if (obs !== exp) $display("FAIL abort_last cyc %0d: got %b want %b", k, obs, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset;
    logic [6:0] exp;
    tc_load = 1'b1;
    tc_in   = 4'd10;
    tick();
    tc_load = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 4'(i), 1'b0, 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL rst_pre step %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i < 7) tick();
    end
    #2 rst = 1'b1;
    #1;
    exp = 7'b0_0000_0_0;
    n_total++;
    if (obs !== exp) $display("FAIL rst_async: got %b want %b", obs, exp);
    else n_pass++;
    #1 rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, 4'(i), (i == 15), 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL rst_rerun step %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      tick();
    end
    exp = 7'b0_1111_0_1;
    n_total++;
    if (obs !== exp) $display("FAIL rst_rerun_done: got %b want %b", obs, exp);
    else n_pass++;
    tick();
    exp = 7'b0_0000_0_0;
    n_total++;
    if (obs !== exp) $display("FAIL rst_rerun_idle: got %b want %b", obs, exp);
    else n_pass++;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    start       = 1'b0;
    abort       = 1'b0;
    tc_load     = 1'b0;
    tc_in       = 4'd0;
    auto_reload = 1'b0;
    test_reset();
    test_default_run();
    test_tc_load();
    test_back_to_back();
    test_auto_reload();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spm_step_sequencer.md
Name: spm_step_sequencer

Overview:
- Parametrised cycle sequencer for the signed serial-parallel multiplier datapath.
- Runs a programmable-length count from 0 to a stored terminal value, with start/busy/done handshake.
- Flags the final step so the datapath can apply sign (two's-complement) correction on the MSB cycle.
- Supports one-shot and auto-reload modes. Replaces the fixed 4-bit compare-against-constant terminal detector.

Parameters:
- CNT_W, 4, counter and terminal-value width in bits.
- DEFAULT_TC, 15, terminal value loaded at reset (16 steps for the 8x8 product). Must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a run; single-cycle pulse or level.
- abort  in  1  cancel the current run.
- tc_load  in  1  load tc_in into the terminal register.
- tc_in  in  CNT_W  new terminal value.
- auto_reload  in  1  1 = restart immediately after the final step.
- busy  out  1  high while in RUN.
- count  out  CNT_W  current step index.
- last  out  1  current step is the final step.
- done  out  1  one-cycle pulse after each completed run.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- States: IDLE, RUN, DONE. All state, count, tc_reg, busy and done are registered.
- last = (state==RUN) && (count==tc_reg). It is combinational from registers only.
- Reset values: state IDLE, count 0, tc_reg DEFAULT_TC, busy 0, done 0, last 0.
- Priority per cycle: rst > abort > normal operation.
- abort (any state): next cycle IDLE, count 0, busy 0. done is not asserted, even when abort coincides with last.
- tc_load:
  - Accepted in IDLE and DONE; tc_reg takes tc_in at the next edge.
  - Ignored in RUN.
  - If tc_load and start occur together, the run uses the new tc_in.
- IDLE:
  - count held at 0.
  - start -> RUN next cycle, count 0, busy 1.
- RUN:
  - If not last: count increments by 1.
  - If last: done is 1 next cycle. auto_reload is sampled in this cycle:
    - auto_reload=1: stay in RUN, count returns to 0, busy stays 1 (no gap).
    - auto_reload=0: go to DONE, busy 0, count holds tc_reg.
  - start in RUN is ignored.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start -> RUN next cycle, count 0 (back-to-back run, no IDLE gap).
  - Otherwise -> IDLE, count 0.
- Run length is tc_reg+1 cycles of busy.
  - tc_reg=0 gives last on the first RUN cycle.
  - tc_reg = 2^CNT_W-1 reaches all-ones; no overflow, because count never exceeds tc_reg.
- Latency: start -> busy is 1 cycle. last -> done is 1 cycle.
- Asserting rst mid-run clears every output asynchronously and restores tc_reg to DEFAULT_TC.

Decomposition:
- Shared package spm_pkg:
  - State enumeration: 2-bit encoding, IDLE=00, RUN=01, DONE=10. Code 11 is illegal and recovers to IDLE.
  - Default CNT_W and DEFAULT_TC constants, shared with the multiplier top.
- Sub-module eq_cmp: parametrised WIDTH equality comparator (a, b -> eq). Instantiated once for count vs tc_reg.

Test Plan:
- Reset then start pulse, DEFAULT_TC=15, auto_reload=0 -> busy high 16 cycles, count 0..15, last only at count 15, done=1 exactly one cycle after, then IDLE with count 0.
- tc_load with tc_in=3 in IDLE, then start -> busy 4 cycles, count 0,1,2,3, done pulse. tc_load=1 with tc_in=9 mid-run -> no effect, next run still 4 steps.
- tc_in=0, start -> one busy cycle with last=1 and count 0, done next cycle. Also start held high in DONE -> immediate rerun with no IDLE gap.
- auto_reload=1, tc=2 -> count sequence 0,1,2,0,1,2, busy continuously high, done pulses at each wrap. Drop auto_reload before a last -> DONE then IDLE.
- abort asserted at count 5 (tc=15) -> IDLE next cycle, count 0, no done. abort coincident with last -> no done.
- rst asserted asynchronously mid-run at count 7, between clock edges -> busy, done, count cleared immediately. tc_reg returns to 15 (verify with the following run length).
